// File: rtl/control_multi_if.sv
// Control bundle between the multi-cycle control FSM and its datapath.
// master: the controller; slave: the datapath that supplies instr/mem_ready.
interface control_multi_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        IRWrite;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        mul_start;
  logic        mul_busy;
  logic        illegal_op;
  logic [3:0]  state_dbg;

  modport master (
    input  instr, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, mul_start, mul_busy, illegal_op,
           state_dbg
  );

  modport slave (
    output instr, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, mul_start, mul_busy, illegal_op,
           state_dbg
  );
endinterface

// File: rtl/control_multi.sv
// Moore control FSM for the multi-cycle MIPS datapath (R/JR/MULTU, LW, SW, ORI, BEQ, J).
// Controls are registered from the next state; only FETCH's IRWrite/PCWrite see mem_ready.
module control_multi #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MUL_CYCLES    = 32
) (
  input logic             clk,
  input logic             rst_n,
  control_multi_if.master bus
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StOriExec  = 4'd9,
    StOriWb    = 4'd10,
    StBranch   = 4'd11,
    StJump     = 4'd12,
    StJr       = 4'd13,
    StMulWait  = 4'd14,
    StTrap     = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;
  localparam logic [5:0] OpOri   = 6'd13;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [7:0] MulLoad = 8'(MUL_CYCLES - 1);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mul_start_q, mul_busy_q, illegal_q;
  logic       ready;
  logic [5:0] opcode, funct;
  logic       unused_instr;

  assign opcode       = bus.instr[31:26];
  assign funct        = bus.instr[5:0];
  assign unused_instr = ^bus.instr[25:6];
  assign ready        = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    state_d = StFetch;
      StFetch:   if (ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpRtype: begin
            if (funct == FnJr)         state_d = StJr;
            else if (funct == FnMultu) state_d = StMulWait;
            else                       state_d = StRExec;
          end
          OpLw, OpSw: state_d = StMemAddr;
          OpOri:      state_d = StOriExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          default:    state_d = StTrap;
        endcase
      end
      StMemAddr:  state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
      StMemRead:  if (ready) state_d = StMemWb;
      StMemWrite: if (ready) state_d = StFetch;
      StRExec:    state_d = StRWb;
      StOriExec:  state_d = StOriWb;
      StMemWb, StRWb, StOriWb, StBranch, StJump, StJr: state_d = StFetch;
      StMulWait:  if (cnt_q == 8'd0) state_d = StFetch;
      StTrap:     state_d = StTrap;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != StMulWait && state_d == StMulWait) begin
      cnt_d = MulLoad;
    end else if (state_q == StMulWait && cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Controls for the state about to be entered, so they leave a flop.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      StFetch: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.pc_write  = 1'b1;
      end
      StDecode:  ctrl_d.alu_src_b = 2'b11;
      StMemAddr: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
      end
      StMemRead: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl_d.memto_reg = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      StMemWrite: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      StRExec: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = 2'b10;
      end
      StRWb: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      StOriExec: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.alu_op    = 2'b11;
      end
      StOriWb:   ctrl_d.reg_write = 1'b1;
      StBranch: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = 2'b01;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = 2'b01;
      end
      StJump: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = 2'b10;
      end
      StJr: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ctrl_q      <= '0;
      cnt_q       <= 8'd0;
      mul_start_q <= 1'b0;
      mul_busy_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      cnt_q       <= cnt_d;
      mul_start_q <= (state_d == StMulWait) && (state_q != StMulWait);
      mul_busy_q  <= (state_d == StMulWait);
      illegal_q   <= illegal_q | (state_d == StTrap);
    end
  end

  // PCWrite is also used by JUMP/JR, where it must not depend on mem_ready.
  assign bus.PCWrite     = ctrl_q.pc_write & (ready | (state_q != StFetch));
  assign bus.IRWrite     = ctrl_q.ir_write & ready;
  assign bus.PCWriteCond = ctrl_q.pc_write_cond;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.MemtoReg    = ctrl_q.memto_reg;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.ALUOp       = ctrl_q.alu_op;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.mul_start   = mul_start_q;
  assign bus.mul_busy    = mul_busy_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_control_multi.sv
// Bench for control_multi: dut_a without memory handshake, dut_b with it; both MUL_CYCLES=4.
module tb_control_multi;

  typedef struct {
    logic [31:0] instr;
    logic        ready;
    logic [3:0]  st;
    logic [18:0] out;
  } vec_t;

  // {PCW PCWC IorD MR MW M2R IRW RD RW ASA}_{ASB}_{AOP}_{PCS}_{start busy illegal}
  localparam logic [18:0] OutIdle    = 19'b0000000000_00_00_00_000;
  localparam logic [18:0] OutFetch   = 19'b1001001000_01_00_00_000;
  localparam logic [18:0] OutFetchW  = 19'b0001000000_01_00_00_000;
  localparam logic [18:0] OutDecode  = 19'b0000000000_11_00_00_000;
  localparam logic [18:0] OutMemAddr = 19'b0000000001_10_00_00_000;
  localparam logic [18:0] OutMemRd   = 19'b0011000000_00_00_00_000;
  localparam logic [18:0] OutMemWb   = 19'b0000010010_00_00_00_000;
  localparam logic [18:0] OutMemWr   = 19'b0010100000_00_00_00_000;
  localparam logic [18:0] OutRExec   = 19'b0000000001_00_10_00_000;
  localparam logic [18:0] OutRWb     = 19'b0000000110_00_00_00_000;
  localparam logic [18:0] OutOriExec = 19'b0000000001_10_11_00_000;
  localparam logic [18:0] OutOriWb   = 19'b0000000010_00_00_00_000;
  localparam logic [18:0] OutBranch  = 19'b0100000001_00_01_01_000;
  localparam logic [18:0] OutJump    = 19'b1000000000_00_00_10_000;
  localparam logic [18:0] OutJr      = 19'b1000000000_00_00_11_000;
  localparam logic [18:0] OutMulFst  = 19'b0000000000_00_00_00_110;
  localparam logic [18:0] OutMul     = 19'b0000000000_00_00_00_010;
  localparam logic [18:0] OutTrap    = 19'b0000000000_00_00_00_001;

  localparam logic [31:0] ILw  = 32'h8C010004;
  localparam logic [31:0] ISw  = 32'hAC010004;
  localparam logic [31:0] IAdd = 32'h00221820;
  localparam logic [31:0] IOri = 32'h3422000F;
  localparam logic [31:0] IBeq = 32'h10220003;
  localparam logic [31:0] IJ   = 32'h08000010;
  localparam logic [31:0] IJr  = 32'h03E00008;
  localparam logic [31:0] IMul = 32'h00220019;
  localparam logic [31:0] IBad = 32'hFC000000;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vec_a[$];
  vec_t vec_b[$];

  always #5 clk = ~clk;

  control_multi_if ifa ();
  control_multi_if ifb ();

  control_multi #(.MEM_HANDSHAKE(1'b0), .MUL_CYCLES(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (ifa)
  );

  control_multi #(.MEM_HANDSHAKE(1'b1), .MUL_CYCLES(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (ifb)
  );

  function automatic vec_t mk(logic [31:0] instr, logic ready, logic [3:0] st, logic [18:0] out);
    vec_t v;
    v.instr = instr;
    v.ready = ready;
    v.st    = st;
    v.out   = out;
    return v;
  endfunction

  function automatic logic [18:0] obs(bit sel);
    if (sel) begin
      return {ifb.PCWrite, ifb.PCWriteCond, ifb.IorD, ifb.MemRead, ifb.MemWrite, ifb.MemtoReg,
              ifb.IRWrite, ifb.RegDst, ifb.RegWrite, ifb.ALUSrcA, ifb.ALUSrcB, ifb.ALUOp,
              ifb.PCSource, ifb.mul_start, ifb.mul_busy, ifb.illegal_op};
    end
    return {ifa.PCWrite, ifa.PCWriteCond, ifa.IorD, ifa.MemRead, ifa.MemWrite, ifa.MemtoReg,
            ifa.IRWrite, ifa.RegDst, ifa.RegWrite, ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp,
            ifa.PCSource, ifa.mul_start, ifa.mul_busy, ifa.illegal_op};
  endfunction

  function automatic logic [3:0] st(bit sel);
    return sel ? ifb.state_dbg : ifa.state_dbg;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic run_row(input bit sel, input int idx, input vec_t r);
    if (sel) begin
      ifb.instr     = r.instr;
      ifb.mem_ready = r.ready;
    end else begin
      ifa.instr     = r.instr;
      ifa.mem_ready = r.ready;
    end
    #1;
    check($sformatf("%s[%0d].state", sel ? "hs" : "nohs", idx), 32'(st(sel)), 32'(r.st));
    check($sformatf("%s[%0d].ctrl", sel ? "hs" : "nohs", idx), 32'(obs(sel)), 32'(r.out));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // No handshake: mem_ready=0 must be ignored; IBad outside DECODE/MEM_ADDR must be ignored.
    vec_a.push_back(mk(ILw,  1'b1, 4'd0,  OutIdle));
    vec_a.push_back(mk(IBad, 1'b0, 4'd1,  OutFetch));
    vec_a.push_back(mk(ILw,  1'b1, 4'd2,  OutDecode));
    vec_a.push_back(mk(ILw,  1'b1, 4'd3,  OutMemAddr));
    vec_a.push_back(mk(IBad, 1'b0, 4'd4,  OutMemRd));
    vec_a.push_back(mk(IBad, 1'b1, 4'd5,  OutMemWb));
    vec_a.push_back(mk(IAdd, 1'b1, 4'd1,  OutFetch));
    vec_a.push_back(mk(IAdd, 1'b1, 4'd2,  OutDecode));
    vec_a.push_back(mk(IAdd, 1'b1, 4'd7,  OutRExec));
    vec_a.push_back(mk(IAdd, 1'b1, 4'd8,  OutRWb));
    vec_a.push_back(mk(IOri, 1'b1, 4'd1,  OutFetch));
    vec_a.push_back(mk(IOri, 1'b1, 4'd2,  OutDecode));
    vec_a.push_back(mk(IOri, 1'b1, 4'd9,  OutOriExec));
    vec_a.push_back(mk(IOri, 1'b1, 4'd10, OutOriWb));
    vec_a.push_back(mk(ISw,  1'b1, 4'd1,  OutFetch));
    vec_a.push_back(mk(ISw,  1'b1, 4'd2,  OutDecode));
    vec_a.push_back(mk(ISw,  1'b1, 4'd3,  OutMemAddr));
    vec_a.push_back(mk(ISw,  1'b0, 4'd6,  OutMemWr));
    vec_a.push_back(mk(IBeq, 1'b1, 4'd1,  OutFetch));
    vec_a.push_back(mk(IBeq, 1'b1, 4'd2,  OutDecode));
    vec_a.push_back(mk(IBeq, 1'b1, 4'd11, OutBranch));
    vec_a.push_back(mk(IJ,   1'b1, 4'd1,  OutFetch));
    vec_a.push_back(mk(IJ,   1'b1, 4'd2,  OutDecode));
    vec_a.push_back(mk(IJ,   1'b1, 4'd12, OutJump));
    vec_a.push_back(mk(IJr,  1'b1, 4'd1,  OutFetch));
    vec_a.push_back(mk(IJr,  1'b1, 4'd2,  OutDecode));
    vec_a.push_back(mk(IJr,  1'b1, 4'd13, OutJr));
    vec_a.push_back(mk(IMul, 1'b1, 4'd1,  OutFetch));
    vec_a.push_back(mk(IMul, 1'b1, 4'd2,  OutDecode));
    vec_a.push_back(mk(IMul, 1'b1, 4'd14, OutMulFst));
    vec_a.push_back(mk(IMul, 1'b1, 4'd14, OutMul));
    vec_a.push_back(mk(IMul, 1'b1, 4'd14, OutMul));
    vec_a.push_back(mk(IMul, 1'b1, 4'd14, OutMul));
    vec_a.push_back(mk(IBad, 1'b1, 4'd1,  OutFetch));
    vec_a.push_back(mk(IBad, 1'b1, 4'd2,  OutDecode));
    for (int i = 0; i < 10; i++) vec_a.push_back(mk((i % 2) ? ILw : IJ, 1'b1, 4'd15, OutTrap));

    // Handshake: FETCH, MEM_WRITE and MEM_READ stretched by mem_ready low.
    vec_b.push_back(mk(ISw,  1'b0, 4'd0,  OutIdle));
    vec_b.push_back(mk(ISw,  1'b0, 4'd1,  OutFetchW));
    vec_b.push_back(mk(ISw,  1'b0, 4'd1,  OutFetchW));
    vec_b.push_back(mk(ISw,  1'b1, 4'd1,  OutFetch));
    vec_b.push_back(mk(ISw,  1'b0, 4'd2,  OutDecode));
    vec_b.push_back(mk(ISw,  1'b0, 4'd3,  OutMemAddr));
    vec_b.push_back(mk(ISw,  1'b0, 4'd6,  OutMemWr));
    vec_b.push_back(mk(ISw,  1'b0, 4'd6,  OutMemWr));
    vec_b.push_back(mk(ISw,  1'b0, 4'd6,  OutMemWr));
    vec_b.push_back(mk(ISw,  1'b1, 4'd6,  OutMemWr));
    vec_b.push_back(mk(ILw,  1'b1, 4'd1,  OutFetch));
    vec_b.push_back(mk(ILw,  1'b1, 4'd2,  OutDecode));
    vec_b.push_back(mk(ILw,  1'b1, 4'd3,  OutMemAddr));
    vec_b.push_back(mk(ILw,  1'b0, 4'd4,  OutMemRd));
    vec_b.push_back(mk(ILw,  1'b1, 4'd4,  OutMemRd));
    vec_b.push_back(mk(ILw,  1'b0, 4'd5,  OutMemWb));
    vec_b.push_back(mk(IMul, 1'b1, 4'd1,  OutFetch));
    vec_b.push_back(mk(IMul, 1'b1, 4'd2,  OutDecode));
    vec_b.push_back(mk(IMul, 1'b1, 4'd14, OutMulFst));
    vec_b.push_back(mk(IMul, 1'b1, 4'd14, OutMul));

    ifa.instr = 32'h0;
    ifa.mem_ready = 1'b0;
    ifb.instr = 32'h0;
    ifb.mem_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_b.ctrl", 32'(obs(1'b1)), 32'(OutIdle));
    check("reset_b.state", 32'(st(1'b1)), 32'd0);
    rst_n_a = 1'b1;
    foreach (vec_a[i]) run_row(1'b0, i, vec_a[i]);

    // Asynchronous reset in the middle of a TRAP cycle.
    @(posedge clk);
    #2 rst_n_a = 1'b0;
    #1;
    check("trap_rst.ctrl", 32'(obs(1'b0)), 32'(OutIdle));
    check("trap_rst.state", 32'(st(1'b0)), 32'd0);
    @(posedge clk);
    #1;
    check("trap_rst_held.ctrl", 32'(obs(1'b0)), 32'(OutIdle));
    @(negedge clk);
    rst_n_a = 1'b1;
    @(posedge clk);
    #1;
    check("trap_rst_fetch.state", 32'(st(1'b0)), 32'd1);
    check("trap_rst_fetch.ctrl", 32'(obs(1'b0)), 32'(OutFetch));

    @(negedge clk);
    rst_n_b = 1'b1;
    foreach (vec_b[i]) run_row(1'b1, i, vec_b[i]);

    // Asynchronous reset mid-MUL_WAIT; then a fresh MULTU must still busy for 4 cycles.
    @(posedge clk);
    #2 rst_n_b = 1'b0;
    #1;
    check("mul_rst.ctrl", 32'(obs(1'b1)), 32'(OutIdle));
    check("mul_rst.state", 32'(st(1'b1)), 32'd0);
    @(negedge clk);
    rst_n_b = 1'b1;
    ifb.mem_ready = 1'b1;
    ifb.instr = IMul;
    #1;
    check("mul_rst_idle.state", 32'(st(1'b1)), 32'd0);
    @(negedge clk);
    begin
      int busy = 0;
      int starts = 0;
      int cyc = 0;
      // FETCH, DECODE, 4x MUL_WAIT, then FETCH again on the 7th sample.
      for (int i = 0; i < 7; i++) begin
        #1;
        if (ifb.mul_busy) busy++;
        if (ifb.mul_start) starts++;
        if (i > 0 && cyc == 0 && st(1'b1) == 4'd1) cyc = i;
        @(negedge clk);
      end
      check("mul_after_rst.busy_cycles", 32'(busy), 32'd4);
      check("mul_after_rst.start_pulses", 32'(starts), 32'd1);
      check("mul_after_rst.cpi", 32'(cyc), 32'd6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
